run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Sequences instruction commit for the single-cycle processor.
- Gates PC advance, register-file and data-memory writes through one commit strobe.
- Stalls on input instructions until the operator confirms with a push-button, supports single-step mode, and latches HLT.
- Sits between the control unit, the board buttons/switches, and the program counter / write enables.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a button level change (1 ms at 50 MHz)
CNT_W, 32, width of the committed-instruction counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
hlt_i  input  1  current instruction is HLT (from control unit)
in_req_i  input  1  current instruction reads switches
out_req_i  input  1  current instruction drives the display
btn_confirm_n  input  1  raw push-button, active-low, asynchronous
btn_step_n  input  1  raw push-button, active-low, asynchronous
step_mode  input  1  slide switch; 1 = single-step
commit_o  output  1  qualifies PC update and all architectural writes this cycle
disp_load_o  output  1  one-cycle load strobe for the BCD/display register
halted_o  output  1  state == HALT
wait_in_o  output  1  state == WAIT_IN
state_o  output  3  encoded FSM state, for debug LEDs
instr_count_o  output  CNT_W  number of committed instructions

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, instr_count=0, debouncer levels=released, pulses=0. All outputs are 0 while reset is asserted and in the first cycle after release.
- Buttons: each raw button passes through a 2-FF synchronizer, is inverted, and is debounced.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
  - A released->pressed change emits a one-cycle registered pulse (conf_p, step_p).
  - Press-to-pulse latency is 2 + DEBOUNCE_CYCLES cycles.
  - A held button produces exactly one pulse.
- FSM states: IDLE, RUN, STEP_WAIT, WAIT_IN, HALT.
- commit_o is Mealy: f(state, hlt_i, in_req_i, conf_p, step_p). Input priority within a cycle: hlt_i > in_req_i > button pulse.
- IDLE: commit_o=0. On conf_p, go to STEP_WAIT if step_mode=1, else RUN.
- RUN:
  - hlt_i=1 -> commit_o=0, go HALT.
  - else in_req_i=1 -> commit_o=0, go WAIT_IN.
  - else commit_o=1; if step_mode=1, go STEP_WAIT after this commit.
- STEP_WAIT:
  - commit_o=0 unless step_p=1.
  - On step_p with hlt_i=1 -> go HALT, no commit.
  - On step_p with in_req_i=1 -> go WAIT_IN, no commit.
  - On step_p otherwise -> commit_o=1, stay.
  - If step_mode=0 and no pulse -> go RUN.
- WAIT_IN: commit_o=0 until conf_p. On conf_p: commit_o=1 (the switch value is written this cycle), then go STEP_WAIT if step_mode=1, else RUN. step_p is ignored.
- HALT: commit_o=0. Exited only by reset; button pulses are ignored.
- disp_load_o = commit_o & out_req_i, same cycle.
- instr_count increments by 1 on every cycle with commit_o=1 and wraps modulo 2^CNT_W without flagging.
- Pulses arriving in a state that does not consume them are discarded, not queued.
- Reset mid-stall (WAIT_IN/STEP_WAIT) returns to IDLE immediately; no commit occurs in that cycle.
- hlt_i and in_req_i are combinational from instruction memory and must be stable before the clock edge; the block adds no latency to them.

Decomposition:
- Shared package run_ctrl_pkg: state encoding constants (IDLE=0, RUN=1, STEP_WAIT=2, WAIT_IN=3, HALT=4) and the DEBOUNCE_CYCLES default.
- One sub-module, button_debounce: synchronizer + debounce counter + edge pulse, with a parameter for the cycle count. Instantiated twice.
- FSM, commit logic and counter live in run_controller.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4.)
- Reset then confirm press -> conf_p 6 cycles after press; state IDLE->RUN; commit_o=1 every cycle; instr_count counts 1,2,3...
- RUN with in_req_i=1 held -> commit_o=0, wait_in_o=1. Confirm press -> exactly one commit_o=1 cycle; instr_count+1; back to RUN.
- step_mode=1 with three step presses (one held 20 cycles) -> exactly three single-cycle commits, one per press; state stays STEP_WAIT.
- hlt_i=1 together with in_req_i=1 and step_p -> HALT, no commit. Later confirm presses -> no change. reset low -> IDLE, count 0 asynchronously.
- Button bounce (toggle every 2 cycles for 10 cycles, then steady low) -> single conf_p only after 4 stable samples.
- CNT_W=4 with 17 commits -> instr_count wraps 15->0->1. out_req_i=1 on a committed cycle -> disp_load_o=1 that cycle only.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// ============================================================================
// Module : run_ctrl_pkg
// Brief  : Shared state encoding and defaults for the run controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_WAIT_IN   = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    localparam int c_DEBOUNCE_CYCLES_DEF = 50000;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module : button_debounce
// Brief  : 2-FF synchronizer, stable-count debouncer and press pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_debounce
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_pulse
);

    localparam int c_CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_pulse;
    logic [c_CW-1:0] r_cnt;
    logic            w_sample;

    assign w_sample = ~r_sync2;
    assign o_pulse  = r_pulse;

    // Counter tracks how many consecutive samples disagree with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_MAX) begin
                r_level <= w_sample;
                r_pulse <= w_sample;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/run_controller.sv
// ============================================================================
// Module : run_controller
// Brief  : Commit sequencer with confirm/step buttons, input stall and HLT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hlt_i,
    input  logic             in_req_i,
    input  logic             out_req_i,
    input  logic             btn_confirm_n,
    input  logic             btn_step_n,
    input  logic             step_mode,
    output logic             commit_o,
    output logic             disp_load_o,
    output logic             halted_o,
    output logic             wait_in_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o
);

    logic             w_conf_p;
    logic             w_step_p;
    logic             w_commit;
    state_t           w_next;
    state_t           r_state;
    logic             r_halted;
    logic             r_wait_in;
    logic [CNT_W-1:0] r_count;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_conf (
        .clk     (clk),
        .rst_n   (reset),
        .i_btn_n (btn_confirm_n),
        .o_pulse (w_conf_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk     (clk),
        .rst_n   (reset),
        .i_btn_n (btn_step_n),
        .o_pulse (w_step_p)
    );

    // Mealy commit: hlt_i outranks in_req_i, which outranks the button pulse.
    always_comb begin
        w_commit = 1'b0;
        w_next   = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_conf_p) w_next = step_mode ? ST_STEP_WAIT : ST_RUN;
            end
            ST_RUN: begin
                if (hlt_i)         w_next = ST_HALT;
                else if (in_req_i) w_next = ST_WAIT_IN;
                else begin
                    w_commit = 1'b1;
                    if (step_mode) w_next = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                if (w_step_p) begin
                    if (hlt_i)         w_next = ST_HALT;
                    else if (in_req_i) w_next = ST_WAIT_IN;
                    else               w_commit = 1'b1;
                end else if (!step_mode) begin
                    w_next = ST_RUN;
                end
            end
            ST_WAIT_IN: begin
                if (w_conf_p) begin
                    w_commit = 1'b1;
                    w_next   = step_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_halted  <= 1'b0;
            r_wait_in <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_next;
            r_halted  <= (w_next == ST_HALT);
            r_wait_in <= (w_next == ST_WAIT_IN);
            if (w_commit) r_count <= r_count + CNT_W'(1);
        end
    end

    assign commit_o      = w_commit;
    assign disp_load_o   = w_commit & out_req_i;
    assign halted_o      = r_halted;
    assign wait_in_o     = r_wait_in;
    assign state_o       = r_state;
    assign instr_count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
// ============================================================================
// Module : tb_run_controller
// Brief  : Directed scenario bench for run_controller (debounce = 4, 4-bit count).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_run_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       hlt_i, in_req_i, out_req_i;
    logic       btn_confirm_n, btn_step_n, step_mode;
    logic       commit_o, disp_load_o, halted_o, wait_in_o;
    logic [2:0] state_o;
    logic [3:0] instr_count_o;

    int tests = 0;
    int fails = 0;

    run_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .hlt_i         (hlt_i),
        .in_req_i      (in_req_i),
        .out_req_i     (out_req_i),
        .btn_confirm_n (btn_confirm_n),
        .btn_step_n    (btn_step_n),
        .step_mode     (step_mode),
        .commit_o      (commit_o),
        .disp_load_o   (disp_load_o),
        .halted_o      (halted_o),
        .wait_in_o     (wait_in_o),
        .state_o       (state_o),
        .instr_count_o (instr_count_o)
    );

    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 2 time units after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; hlt_i = 1'b0; in_req_i = 1'b0; out_req_i = 1'b0;
        btn_confirm_n = 1'b1; btn_step_n = 1'b1; step_mode = 1'b0;
        cyc(3);
        tests++;
        if ({commit_o, disp_load_o, halted_o, wait_in_o, state_o, instr_count_o} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0", {commit_o, disp_load_o, halted_o, wait_in_o, state_o, instr_count_o});
        end
        reset = 1'b1;
        cyc(1);
        tests++;
        if ({commit_o, disp_load_o, halted_o, wait_in_o, state_o, instr_count_o} !== 11'd0) begin
            fails++;
            $display("FAIL reset_release: got %b want 0", {commit_o, disp_load_o, halted_o, wait_in_o, state_o, instr_count_o});
        end
    endtask

    task automatic test_start_run();
        btn_confirm_n = 1'b0;
        cyc(6);
        tests++;
        if (state_o !== 3'd0 || commit_o !== 1'b0) begin
            fails++;
            $display("FAIL start_pulse_cycle: state %0d commit %b want 0 0", state_o, commit_o);
        end
        cyc(1);
        tests++;
        if (state_o !== 3'd1 || commit_o !== 1'b1 || instr_count_o !== 4'd0) begin
            fails++;
            $display("FAIL start_run: state %0d commit %b count %0d want 1 1 0", state_o, commit_o, instr_count_o);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc(1);
            if (k == 2) btn_confirm_n = 1'b1;
            tests++;
            if (instr_count_o !== 4'(k) || commit_o !== 1'b1) begin
                fails++;
                $display("FAIL run_count: count %0d commit %b want %0d 1", instr_count_o, commit_o, k);
            end
        end
    endtask

    task automatic test_wait_in();
        in_req_i = 1'b1;
        #1;
        tests++;
        if (commit_o !== 1'b0 || disp_load_o !== 1'b0) begin
            fails++;
            $display("FAIL in_req_nocommit: commit %b disp %b want 0 0", commit_o, disp_load_o);
        end
        cyc(1);
        tests++;
        if (state_o !== 3'd3 || wait_in_o !== 1'b1 || instr_count_o !== 4'd3) begin
            fails++;
            $display("FAIL wait_in_enter: state %0d wait %b count %0d want 3 1 3", state_o, wait_in_o, instr_count_o);
        end
        cyc(7);
        btn_confirm_n = 1'b0;
        cyc(5);
        tests++;
        if (commit_o !== 1'b0 || state_o !== 3'd3) begin
            fails++;
            $display("FAIL wait_in_hold: commit %b state %0d want 0 3", commit_o, state_o);
        end
        cyc(1);
        tests++;
        if (commit_o !== 1'b1 || state_o !== 3'd3) begin
            fails++;
            $display("FAIL wait_in_confirm: commit %b state %0d want 1 3", commit_o, state_o);
        end
        in_req_i = 1'b0;
        cyc(1);
        tests++;
        if (state_o !== 3'd1 || instr_count_o !== 4'd4 || wait_in_o !== 1'b0) begin
            fails++;
            $display("FAIL wait_in_exit: state %0d count %0d wait %b want 1 4 0", state_o, instr_count_o, wait_in_o);
        end
        btn_confirm_n = 1'b1;
    endtask

    task automatic test_step_mode();
        int holds[3] = '{13, 0, 2};
        step_mode = 1'b1;
        #1;
        tests++;
        if (commit_o !== 1'b1) begin
            fails++;
            $display("FAIL step_last_run_commit: got %b want 1", commit_o);
        end
        cyc(1);
        tests++;
        if (state_o !== 3'd2 || instr_count_o !== 4'd5 || commit_o !== 1'b0) begin
            fails++;
            $display("FAIL step_enter: state %0d count %0d commit %b want 2 5 0", state_o, instr_count_o, commit_o);
        end
        for (int p = 0; p < 3; p++) begin
            btn_step_n = 1'b0;
            cyc(6);
            tests++;
            if (commit_o !== 1'b1) begin
                fails++;
                $display("FAIL step_commit_%0d: got %b want 1", p, commit_o);
            end
            cyc(1);
            tests++;
            if (instr_count_o !== 4'(6 + p) || commit_o !== 1'b0 || state_o !== 3'd2) begin
                fails++;
                $display("FAIL step_after_%0d: count %0d commit %b state %0d want %0d 0 2",
                         p, instr_count_o, commit_o, state_o, 6 + p);
            end
            cyc(holds[p]);
            tests++;
            if (instr_count_o !== 4'(6 + p)) begin
                fails++;
                $display("FAIL step_held_%0d: count %0d want %0d", p, instr_count_o, 6 + p);
            end
            btn_step_n = 1'b1;
            cyc(7);
        end
    endtask

    task automatic test_halt();
        hlt_i = 1'b1; in_req_i = 1'b1; btn_step_n = 1'b0;
        cyc(6);
        tests++;
        if (commit_o !== 1'b0 || disp_load_o !== 1'b0) begin
            fails++;
            $display("FAIL halt_nocommit: commit %b disp %b want 0 0", commit_o, disp_load_o);
        end
        cyc(1);
        tests++;
        if (state_o !== 3'd4 || halted_o !== 1'b1 || instr_count_o !== 4'd8) begin
            fails++;
            $display("FAIL halt_enter: state %0d halted %b count %0d want 4 1 8", state_o, halted_o, instr_count_o);
        end
        btn_step_n = 1'b1; hlt_i = 1'b0; in_req_i = 1'b0;
        cyc(7);
        btn_confirm_n = 1'b0;
        cyc(8);
        tests++;
        if (state_o !== 3'd4 || instr_count_o !== 4'd8 || commit_o !== 1'b0) begin
            fails++;
            $display("FAIL halt_sticky: state %0d count %0d commit %b want 4 8 0", state_o, instr_count_o, commit_o);
        end
        btn_confirm_n = 1'b1;
        reset = 1'b0;
        #1;
        tests++;
        if (state_o !== 3'd0 || instr_count_o !== 4'd0 || halted_o !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: state %0d count %0d halted %b want 0 0 0", state_o, instr_count_o, halted_o);
        end
        step_mode = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        tests++;
        if (state_o !== 3'd0 || commit_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_rerelease: state %0d commit %b want 0 0", state_o, commit_o);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            btn_confirm_n = ((i / 2) % 2 == 1);
            cyc(1);
            tests++;
            if (state_o !== 3'd0 || commit_o !== 1'b0) begin
                fails++;
                $display("FAIL bounce_%0d: state %0d commit %b want 0 0", i, state_o, commit_o);
            end
        end
        cyc(4);
        tests++;
        if (state_o !== 3'd0) begin
            fails++;
            $display("FAIL bounce_pulse_cycle: state %0d want 0", state_o);
        end
        cyc(1);
        tests++;
        if (state_o !== 3'd1 || commit_o !== 1'b1 || instr_count_o !== 4'd0) begin
            fails++;
            $display("FAIL bounce_run: state %0d commit %b count %0d want 1 1 0", state_o, commit_o, instr_count_o);
        end
        btn_confirm_n = 1'b1;
    endtask

    task automatic test_wrap_disp();
        cyc(15);
        tests++;
        if (instr_count_o !== 4'd15) begin
            fails++;
            $display("FAIL wrap_15: got %0d want 15", instr_count_o);
        end
        cyc(1);
        tests++;
        if (instr_count_o !== 4'd0) begin
            fails++;
            $display("FAIL wrap_0: got %0d want 0", instr_count_o);
        end
        cyc(1);
        tests++;
        if (instr_count_o !== 4'd1) begin
            fails++;
            $display("FAIL wrap_1: got %0d want 1", instr_count_o);
        end
        out_req_i = 1'b1;
        #1;
        tests++;
        if (disp_load_o !== 1'b1) begin
            fails++;
            $display("FAIL disp_on_commit: got %b want 1", disp_load_o);
        end
        cyc(1);
        out_req_i = 1'b0;
        #1;
        tests++;
        if (disp_load_o !== 1'b0) begin
            fails++;
            $display("FAIL disp_clear: got %b want 0", disp_load_o);
        end
        out_req_i = 1'b1; in_req_i = 1'b1;
        #1;
        tests++;
        if (disp_load_o !== 1'b0 || commit_o !== 1'b0) begin
            fails++;
            $display("FAIL disp_no_commit: disp %b commit %b want 0 0", disp_load_o, commit_o);
        end
        out_req_i = 1'b0; in_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_run();
        test_wait_in();
        test_step_mode();
        test_halt();
        test_bounce();
        test_wrap_disp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
